idu_pipe_stage: RTL
===================

Name: idu_pipe_stage

Overview:
- Registered, handshaked instruction-decode stage for the RV32 core, sitting between IFU and EXU.
- Decodes RV32I, with optional RV32E register restriction and optional M-extension decode.
- Flags illegal instructions, ecall and ebreak as outputs.
- Holds one decoded instruction in an output register plus one skid entry, giving full throughput under backpressure.

Parameters:
- NREG, 32, architectural register count: 32 for RV32I, 16 for RV32E. Any rs1/rs2/rd index >= NREG is illegal.
- EN_M, 0, when 1 decode MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (opcode 0x33, funct7 0x01). When 0 these are illegal.
- EN_SYS, 1, when 1 decode ecall (0x00000073) and ebreak (0x00100073). When 0 both are illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  IFU offers inst/pc.
- in_ready  out  1  stage can accept.
- in_inst  in  32  instruction word.
- in_pc  in  32  instruction address.
- flush  in  1  discard all held entries (redirect).
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  EXU accepts.
- out_pc  out  32  pc of bundle.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_imm  out  32  sign-extended immediate by format (I/S/B/U/J); 0 for R-type.
- out_alu_func  out  4  0 add, 8 sub, 1 sll, 5 srl, 13 sra, 2 slt, 3 sltu, 4 xor, 6 or, 7 and, 14 lui-pass.
- out_mdu_en  out  1  M-extension op (EN_M=1 only).
- out_mdu_func  out  3  funct3 of the M op.
- out_alu_a_sel, out_alu_b_sel  out  1 each  same meaning as the current decoder.
- out_w_en  out  1  register write; forced 0 when illegal or rd==0.
- out_w_sel  out  2  01 pc+4, 10 ALU/MDU, 11 load data, 00 none.
- out_branch_type  out  3  1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu, 0 none.
- out_jump  out  1  jal or jalr.
- out_is_jal, out_is_jalr  out  1 each  for ftrace.
- out_mem_op  out  4  {is_store, signed, size[1:0]}; 0 when not a memory op.
- out_mem_en  out  1  load or store.
- out_illegal, out_ecall, out_ebreak  out  1 each.
- dec_count  out  32  bundles handed to EXU (out_valid & out_ready), wraps at 2^32.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, skid empty, in_ready=1, dec_count=0. All out_* data fields = 0.
- Decode is combinational on in_inst; the result is captured on an accepted transfer (in_valid & in_ready).
- Latency: accepted at edge N, out_valid=1 after edge N. Sustained throughput is 1 per cycle while out_ready=1.
- Output register behaviour:
  - Loads when empty, or when its entry is consumed in the same cycle.
  - If the output register is full and not consumed, an accepted bundle goes to the skid entry.
  - in_ready = skid empty (registered; no combinational path from out_ready to in_ready).
  - When the output register is consumed, the skid entry moves to it; skid empty -> in_ready=1 next cycle.
  - Order is strictly preserved; no duplication or loss.
- Flush:
  - Clears out_valid and the skid on the next edge.
  - An input offered in the same cycle is dropped (flush has priority).
  - in_ready=1 the cycle after a flush.
  - A bundle with out_valid&out_ready in the flush cycle still counts in dec_count.
- Illegal when any of:
  - unknown opcode or funct3/funct7 combination;
  - register index >= NREG in a used field;
  - M op with EN_M=0;
  - SYSTEM op other than ecall/ebreak, or SYSTEM op with EN_SYS=0.
- Illegal bundles still flow with out_illegal=1, w_en=0, mem_en=0, jump=0, branch_type=0.
- ebreak/ecall are single-cycle flags on the bundle. They are not a simulation hook; trap handling belongs to the consumer.
- Shift-immediates require funct7 0x00 (0x20 for srai), else illegal.
- With out_valid=0, data outputs hold their last value; consumers qualify them with out_valid.

Test Plan:
- Basic decode: reset, then in_inst=0x00500093 (addi x1,x0,5) in a single cycle, out_ready=1 -> next cycle out_valid=1, rd=1, imm=5, alu_func=0, w_sel=10, w_en=1; dec_count=1 after the consume.
- Branch: 0x0020F463 (bgeu x1,x2,+8) -> branch_type=6, imm=8, w_en=0, jump=0. Sweep beq..bgeu -> codes 1..6.
- Backpressure: stream 4 addis with out_ready=0 -> two held (output + skid), in_ready=0 from the 3rd cycle. Then out_ready=1 -> all 4 emerge in order, one per cycle, dec_count=4.
- Flush: skid and output full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered instruction never appears.
- RV32E and illegal: NREG=16, 0x00208833 (add x16,x1,x2) -> illegal=1, w_en=0. EN_M=0 with 0x02208033 (mul) -> illegal=1; with EN_M=1 -> mdu_en=1, mdu_func=0.
- System ops and reset: 0x00100073 -> ebreak=1; 0x00000073 -> ecall=1. Assert rst_n low mid-stream -> out_valid=0 and dec_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/idu_pipe_stage_if.sv
// idu_pipe_stage_if: IFU-side handshake, EXU-side decoded bundle and stats of the decode stage
interface idu_pipe_stage_if;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, out_imm, dec_count;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_alu_func, out_mem_op;
  logic [2:0]  out_mdu_func, out_branch_type;
  logic [1:0]  out_w_sel;
  logic        out_mdu_en, out_alu_a_sel, out_alu_b_sel, out_w_en, out_jump, out_is_jal, out_is_jalr;
  logic        out_mem_en, out_illegal, out_ecall, out_ebreak;
  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_imm, dec_count, out_rs1, out_rs2, out_rd,
           out_alu_func, out_mem_op, out_mdu_func, out_branch_type, out_w_sel, out_mdu_en,
           out_alu_a_sel, out_alu_b_sel, out_w_en, out_jump, out_is_jal, out_is_jalr,
           out_mem_en, out_illegal, out_ecall, out_ebreak
  );
  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, dec_count, out_rs1, out_rs2, out_rd,
           out_alu_func, out_mem_op, out_mdu_func, out_branch_type, out_w_sel, out_mdu_en,
           out_alu_a_sel, out_alu_b_sel, out_w_en, out_jump, out_is_jal, out_is_jalr,
           out_mem_en, out_illegal, out_ecall, out_ebreak
  );
endinterface

// File: rtl/idu_pipe_stage.sv
// idu_pipe_stage: registered RV32I/E(+M) decode stage with output register and one skid entry
module idu_pipe_stage #(
  parameter int NREG   = 32,
  parameter bit EN_M   = 1'b0,
  parameter bit EN_SYS = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  idu_pipe_stage_if.slave bus
);
  typedef struct packed {
    logic [31:0] pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_func, mem_op;
    logic [2:0]  mdu_func, branch_type;
    logic [1:0]  w_sel;
    logic        mdu_en, a_sel, b_sel, w_en, jump, is_jal, is_jalr, mem_en, illegal, ecall, ebreak;
  } bundle_t;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13;
  localparam logic [6:0] OP_REG = 7'h33, OP_FENCE = 7'h0f, OP_SYS = 7'h73;
  localparam logic [5:0] NR = 6'(NREG);
  logic [31:0] i, i_imm, s_imm, b_imm, u_imm, j_imm, cnt;
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic        use_rd, use_rs1, use_rs2, bad, acc, pop, o_v, s_v;
  bundle_t     d, o, s;
  assign i     = bus.in_inst;
  assign op    = i[6:0];
  assign f3    = i[14:12];
  assign f7    = i[31:25];
  assign i_imm = {{20{i[31]}}, i[31:20]};
  assign s_imm = {{20{i[31]}}, i[31:25], i[11:7]};
  assign b_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  assign u_imm = {i[31:12], 12'b0};
  assign j_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  always_comb begin
    d = '0;
    d.pc = bus.in_pc;
    d.rs1 = i[19:15];
    d.rs2 = i[24:20];
    d.rd = i[11:7];
    bad = 1'b0;
    use_rd = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (op)
      OP_LUI: begin
        use_rd = 1'b1; d.imm = u_imm; d.alu_func = 4'd14; d.b_sel = 1'b1; d.w_sel = 2'b10;
      end
      OP_AUIPC: begin
        use_rd = 1'b1; d.imm = u_imm; d.a_sel = 1'b1; d.b_sel = 1'b1; d.w_sel = 2'b10;
      end
      OP_JAL: begin
        use_rd = 1'b1; d.imm = j_imm; d.a_sel = 1'b1; d.b_sel = 1'b1; d.w_sel = 2'b01;
        d.jump = 1'b1; d.is_jal = 1'b1;
      end
      OP_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1; d.imm = i_imm; d.b_sel = 1'b1; d.w_sel = 2'b01;
        d.jump = 1'b1; d.is_jalr = 1'b1; bad = f3 != 3'd0;
      end
      OP_BR: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; d.imm = b_imm;
        d.branch_type = f3[2] ? f3 - 3'd1 : f3 + 3'd1;
        bad = f3[2:1] == 2'b01;
      end
      OP_LD: begin
        use_rd = 1'b1; use_rs1 = 1'b1; d.imm = i_imm; d.b_sel = 1'b1; d.w_sel = 2'b11;
        d.mem_en = 1'b1; d.mem_op = {1'b0, ~f3[2], f3[1:0]};
        bad = f3[1] & (f3[0] | f3[2]);
      end
      OP_ST: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; d.imm = s_imm; d.b_sel = 1'b1;
        d.mem_en = 1'b1; d.mem_op = {2'b10, f3[1:0]};
        bad = f3[2] | (f3[1] & f3[0]);
      end
      OP_IMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1; d.imm = i_imm; d.b_sel = 1'b1; d.w_sel = 2'b10;
        d.alu_func = {f7[5] & (f3 == 3'd5), f3};
        bad = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      OP_REG: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; d.w_sel = 2'b10;
        d.mdu_en = f7 == 7'h01;
        d.mdu_func = f3;
        d.alu_func = d.mdu_en ? 4'd0 : {f7[5], f3};
        bad = d.mdu_en ? !EN_M : !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      OP_FENCE: bad = f3 != 3'd0;
      OP_SYS: begin
        d.ecall = EN_SYS && i == 32'h0000_0073;
        d.ebreak = EN_SYS && i == 32'h0010_0073;
        bad = !(d.ecall || d.ebreak);
      end
      default: bad = 1'b1;
    endcase
    if ((use_rd && {1'b0, d.rd} >= NR) || (use_rs1 && {1'b0, d.rs1} >= NR) || (use_rs2 && {1'b0, d.rs2} >= NR))
      bad = 1'b1;
    d.illegal = bad;
    d.w_en = use_rd && d.rd != 5'd0 && !bad;
    if (bad) begin
      d.mem_en = 1'b0; d.mem_op = 4'd0; d.jump = 1'b0; d.is_jal = 1'b0; d.is_jalr = 1'b0;
      d.branch_type = 3'd0; d.mdu_en = 1'b0; d.ecall = 1'b0; d.ebreak = 1'b0;
    end
  end
  assign acc = bus.in_valid && !s_v;
  assign pop = o_v && bus.out_ready;
  // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_v <= 1'b0;
      s_v <= 1'b0;
      o <= '0;
      s <= '0;
      cnt <= '0;
    end else begin
      cnt <= cnt + {31'b0, pop};
      if (bus.flush) begin
        o_v <= 1'b0;
        s_v <= 1'b0;
      end else if (pop || !o_v) begin
        if (s_v) begin
          o <= s;
          s_v <= 1'b0;
        end else begin
          o_v <= acc;
          if (acc) o <= d;
        end
      end else if (acc) begin
        s <= d;
        s_v <= 1'b1;
      end
    end
  end
  assign bus.in_ready        = !s_v;
  assign bus.out_valid       = o_v;
  assign bus.dec_count       = cnt;
  assign bus.out_pc          = o.pc;
  assign bus.out_imm         = o.imm;
  assign bus.out_rs1         = o.rs1;
  assign bus.out_rs2         = o.rs2;
  assign bus.out_rd          = o.rd;
  assign bus.out_alu_func    = o.alu_func;
  assign bus.out_mem_op      = o.mem_op;
  assign bus.out_mdu_func    = o.mdu_func;
  assign bus.out_branch_type = o.branch_type;
  assign bus.out_w_sel       = o.w_sel;
  assign bus.out_mdu_en      = o.mdu_en;
  assign bus.out_alu_a_sel   = o.a_sel;
  assign bus.out_alu_b_sel   = o.b_sel;
  assign bus.out_w_en        = o.w_en;
  assign bus.out_jump        = o.jump;
  assign bus.out_is_jal      = o.is_jal;
  assign bus.out_is_jalr     = o.is_jalr;
  assign bus.out_mem_en      = o.mem_en;
  assign bus.out_illegal     = o.illegal;
  assign bus.out_ecall       = o.ecall;
  assign bus.out_ebreak      = o.ebreak;
endmodule
